// File: rtl/alu_pipe_if.sv
// Operation/result handshake bundle for alu_pipe.
// master drives operations and accepts results; slave is the ALU itself.
interface alu_pipe_if #(
   parameter int WIDTH = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] opA;
   logic [WIDTH-1:0] opB;
   logic [3:0]       opS;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] Result;
   logic [4:0]       flags;

   modport master (
      output in_valid, opA, opB, opS, out_ready,
      input  in_ready, out_valid, Result, flags
   );

   modport slave (
      input  in_valid, opA, opB, opS, out_ready,
      output in_ready, out_valid, Result, flags
   );
endinterface

// File: rtl/alu_pipe.sv
// Two-stage valid/ready ALU pipeline; flags are {E, V, N, Z, C}.
// Define ALU_PIPE_SAT_EN to make ADD saturate high and SUB clamp at zero.
module alu_pipe #(
   parameter int WIDTH = 8
) (
   input logic     clk,
   input logic     rst_n,
   alu_pipe_if.slave bus
);
   localparam int SH_W = $clog2(WIDTH);

   logic                    vld_p1;
   logic signed [WIDTH-1:0] opA_p1;
   logic signed [WIDTH-1:0] opB_p1;
   logic [3:0]              opS_p1;
   logic                    vld_p2;
   logic [WIDTH-1:0]        result_p2;
   logic [4:0]              flags_p2;
   logic                    adv1;
   logic                    adv2;

   function automatic logic [WIDTH-1:0] satAdd(input logic [WIDTH:0] sumX);
`ifdef ALU_PIPE_SAT_EN
      return sumX[WIDTH] ? '1 : sumX[WIDTH-1:0];
`else
      return sumX[WIDTH-1:0];
`endif
   endfunction

   function automatic logic [WIDTH-1:0] satSub(input logic [WIDTH:0] diffX);
`ifdef ALU_PIPE_SAT_EN
      return diffX[WIDTH] ? '0 : diffX[WIDTH-1:0];
`else
      return diffX[WIDTH-1:0];
`endif
   endfunction

   // Returns {E, V, N, Z, C, Result}; C and V always describe the unsaturated op.
   function automatic logic [WIDTH+4:0] aluEval(input logic signed [WIDTH-1:0] a,
                                                input logic signed [WIDTH-1:0] b,
                                                input logic [3:0]              op);
      logic [WIDTH:0]       sumX;
      logic [WIDTH:0]       diffX;
      logic [2*WIDTH-1:0]   dbl;
      logic [WIDTH-1:0]     res;
      logic                 e;
      logic                 v;
      logic                 c;
      sumX  = {1'b0, a} + {1'b0, b};
      diffX = {1'b0, a} - {1'b0, b};
      dbl   = '0;
      res   = '0;
      e     = 1'b0;
      v     = 1'b0;
      c     = 1'b0;
      case (op)
         4'd0:  res = '0;
         4'd1: begin
            res = satAdd(sumX);
            c   = sumX[WIDTH];
            v   = (a[WIDTH-1] == b[WIDTH-1]) && (sumX[WIDTH-1] != a[WIDTH-1]);
         end
         4'd2: begin
            res = satSub(diffX);
            c   = diffX[WIDTH];
            v   = (a[WIDTH-1] != b[WIDTH-1]) && (diffX[WIDTH-1] != a[WIDTH-1]);
         end
         4'd3:  res = a & b;
         4'd4:  res = a | b;
         4'd5:  res = a ^ b;
         4'd6:  res = ~a;
         4'd7: begin
            res = {a[WIDTH-2:0], 1'b0};
            c   = a[WIDTH-1];
         end
         4'd8: begin
            res = {1'b0, a[WIDTH-1:1]};
            c   = a[0];
         end
         4'd9: begin
            dbl = {a, a} << b[SH_W-1:0];
            res = dbl[2*WIDTH-1:WIDTH];
         end
         4'd10: begin
            dbl = {a, a} >> b[SH_W-1:0];
            res = dbl[WIDTH-1:0];
         end
         4'd11: begin
            res = a >>> 1;
            c   = a[0];
         end
         default: e = 1'b1;
      endcase
      return {e, v, res[WIDTH-1], (res == '0), c, res};
   endfunction

   assign adv2          = !vld_p2 || bus.out_ready;
   assign adv1          = !vld_p1 || adv2;
   assign bus.in_ready  = adv1;
   assign bus.out_valid = vld_p2;
   assign bus.Result    = result_p2;
   assign bus.flags     = flags_p2;

   // Stage 1: operand/opcode capture
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         vld_p1 <= 1'b0;
      end else if (adv1) begin
         vld_p1 <= bus.in_valid;
      end
   end

   always_ff @(posedge clk) begin
      if (adv1 && bus.in_valid) begin
         opA_p1 <= bus.opA;
         opB_p1 <= bus.opB;
         opS_p1 <= bus.opS;
      end
   end

   // Stage 2: result and flags
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         vld_p2    <= 1'b0;
         result_p2 <= '0;
         flags_p2  <= '0;
      end else if (adv2) begin
         vld_p2 <= vld_p1;
         if (vld_p1) begin
            {flags_p2, result_p2} <= aluEval(opA_p1, opB_p1, opS_p1);
         end
      end
   end
endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe: driver pushes expected {flags, Result},
// an independent monitor pops and compares on every consumed result.
module tb_alu_pipe;
   localparam int WIDTH = 8;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   alu_pipe_if #(.WIDTH(WIDTH)) bus ();
   alu_pipe #(.WIDTH(WIDTH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   int          checkCnt = 0;
   int          passCnt = 0;
   int          cyc = 0;
   int          readyPct = 100;
   int          popCount = 0;
   logic [12:0] sb[$];
   int          popLog[$];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checkCnt++;
      if (act === exp) passCnt++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
   endtask

   // Behavioural model: plain integer arithmetic on the WIDTH=8 operation table.
   function automatic logic [12:0] model(input logic [7:0] a8, input logic [7:0] b8,
                                         input logic [3:0] op);
      int a = int'(a8);
      int b = int'(b8);
      int sa = (a >= 128) ? a - 256 : a;
      int sb2 = (b >= 128) ? b - 256 : b;
      int r = 0;
      int s;
      bit e = 0, v = 0, c = 0;
      bit sat = 0;
`ifdef ALU_PIPE_SAT_EN
      sat = 1;
`endif
      case (op)
         0: r = 0;
         1: begin
            r = a + b; c = (r > 255); s = sa + sb2; v = (s > 127) || (s < -128);
            if (c) r = sat ? 255 : r - 256;
         end
         2: begin
            r = a - b; c = (r < 0); s = sa - sb2; v = (s > 127) || (s < -128);
            if (c) r = sat ? 0 : r + 256;
         end
         3: r = a & b;
         4: r = a | b;
         5: r = a ^ b;
         6: r = 255 - a;
         7: begin r = (a * 2) % 256; c = (a >= 128); end
         8: begin r = a / 2; c = (a % 2) == 1; end
         9: begin r = a; repeat (b % 8) r = ((r * 2) % 256) + (r / 128); end
         10: begin r = a; repeat (b % 8) r = (r / 2) + ((r % 2) * 128); end
         11: begin r = a / 2 + ((a >= 128) ? 128 : 0); c = (a % 2) == 1; end
         default: begin r = 0; e = 1; end
      endcase
      return {e, v, (r >= 128), (r == 0), c, 8'(r)};
   endfunction

   // out_ready changes only just after the rising edge, following readyPct.
   initial begin
      bus.out_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         bus.out_ready = (int'($urandom_range(99)) < readyPct);
      end
   end

   // Monitor: compares every consumed result and checks hold stability under stall.
   initial begin
      bit          holdVld = 0;
      logic [12:0] held = '0;
      logic [12:0] exp;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            holdVld = 0;
         end else begin
            if (holdVld)
               check("hold_stable", {bus.out_valid, bus.flags, bus.Result}, {1'b1, held});
            if (bus.out_valid && bus.out_ready) begin
               popCount++;
               popLog.push_back(cyc);
               if (sb.size() == 0) begin
                  check("unexpected_result", {bus.flags, bus.Result}, 13'h1fff);
               end else begin
                  exp = sb.pop_front();
                  check("result_flags", {bus.flags, bus.Result}, exp);
               end
            end
            holdVld = bus.out_valid && !bus.out_ready;
            held = {bus.flags, bus.Result};
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
      $fatal(1);
   end

   task automatic setReady(input int pct);
      readyPct = pct;
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op,
                        input logic [12:0] exp, output int accCyc);
      int n = 0;
      bus.in_valid = 1'b1;
      bus.opA = a;
      bus.opB = b;
      bus.opS = op;
      @(negedge clk);
      while (!bus.in_ready && n < 500) begin
         @(negedge clk);
         n++;
      end
      accCyc = cyc;
      if (bus.in_ready) sb.push_back(exp);
      else check("accept_timeout", bus.in_ready, 1);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while ((sb.size() != 0 || bus.out_valid) && n < 3000) begin
         @(negedge clk);
         n++;
      end
      check("drain_empty", sb.size(), 0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      int          acc;
      int          acc0;
      int          accepted;
      int          p;
      logic [7:0]  ra, rb;
      logic [3:0]  rop;
      logic [7:0]  stA[4];
      logic [3:0]  stOp[4];
      logic [12:0] exp029[9];

      bus.in_valid = 1'b0;
      bus.opA = '0;
      bus.opB = '0;
      bus.opS = '0;

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_result", bus.Result, 0);
      check("rst_flags", bus.flags, 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      check("post_rst_in_ready", bus.in_ready, 1);
      @(posedge clk);
      #1;

      // Back-to-back opcodes 0..8 with A=15, B=51
      exp029[0] = {5'b00010, 8'd0};
      exp029[1] = {5'b00000, 8'd66};
      exp029[2] = {5'b00101, 8'd220};
      exp029[3] = {5'b00000, 8'b00000011};
      exp029[4] = {5'b00000, 8'b00111111};
      exp029[5] = {5'b00000, 8'b00111100};
      exp029[6] = {5'b00100, 8'b11110000};
      exp029[7] = {5'b00000, 8'b00011110};
      exp029[8] = {5'b00001, 8'b00000111};
      popLog.delete();
      acc0 = 0;
      for (int i = 0; i < 9; i++) begin
         issue(8'd15, 8'd51, 4'(i), exp029[i], acc);
         if (i == 0) acc0 = acc;
      end
      drain();
      check("b2b_pop_count", popLog.size(), 9);
      if (popLog.size() >= 9) begin
         check("b2b_latency", popLog[0] - acc0, 2);
         check("b2b_throughput", popLog[8] - popLog[0], 8);
      end

      // ADD carry, rotates, arithmetic shift
`ifdef ALU_PIPE_SAT_EN
      issue(8'd200, 8'd100, 4'd1, {5'b00101, 8'd255}, acc);
      issue(8'd10, 8'd20, 4'd2, {5'b00011, 8'd0}, acc);
`else
      issue(8'd200, 8'd100, 4'd1, {5'b00001, 8'd44}, acc);
      issue(8'd10, 8'd20, 4'd2, {5'b00101, 8'd246}, acc);
`endif
      issue(8'h81, 8'd3, 4'd9, {5'b00000, 8'h0C}, acc);
      issue(8'h81, 8'd3, 4'd10, {5'b00000, 8'h30}, acc);
      issue(8'h80, 8'd0, 4'd11, {5'b00100, 8'hC0}, acc);
      issue(8'h7F, 8'h01, 4'd1, model(8'h7F, 8'h01, 4'd1), acc);
      drain();

      // Backpressure: four offered with out_ready held low
      stA = '{8'd1, 8'd2, 8'd3, 8'd4};
      stOp = '{4'd1, 4'd5, 4'd6, 4'd7};
      setReady(0);
      setReady(0);
      accepted = 0;
      p = popCount;
      for (int i = 0; i < 4; i++) begin
         bus.in_valid = 1'b1;
         bus.opA = stA[accepted];
         bus.opB = 8'd9;
         bus.opS = stOp[accepted];
         @(negedge clk);
         if (bus.in_ready) begin
            sb.push_back(model(stA[accepted], 8'd9, stOp[accepted]));
            accepted++;
         end
         @(posedge clk);
         #1;
      end
      bus.in_valid = 1'b0;
      check("stall_accepted", accepted, 2);
      @(negedge clk);
      check("stall_in_ready", bus.in_ready, 0);
      @(posedge clk);
      #1;
      setReady(100);
      for (int i = accepted; i < 4; i++)
         issue(stA[i], 8'd9, stOp[i], model(stA[i], 8'd9, stOp[i]), acc);
      drain();
      check("stall_all_emerged", popCount - p, 4);

      // Reset with two operations in flight
      setReady(0);
      setReady(0);
      issue(8'd5, 8'd6, 4'd1, model(8'd5, 8'd6, 4'd1), acc);
      issue(8'd7, 8'd8, 4'd2, model(8'd7, 8'd8, 4'd2), acc);
      rst_n = 1'b0;
      sb.delete();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      check("midrst_out_valid", bus.out_valid, 0);
      check("midrst_in_ready", bus.in_ready, 1);
      check("midrst_result", bus.Result, 0);
      @(posedge clk);
      #1;
      setReady(100);
      p = popCount;
      repeat (6) @(negedge clk);
      check("no_stale_result", popCount - p, 0);
      @(posedge clk);
      #1;
      issue(8'h55, 8'h12, 4'd13, {5'b10010, 8'd0}, acc);
      drain();

      // Randomised traffic with random backpressure and idle gaps
      setReady(60);
      repeat (300) begin
         if ($urandom_range(3) == 0) begin
            @(posedge clk);
            #1;
         end
         ra = 8'($urandom);
         rb = 8'($urandom);
         rop = 4'($urandom_range(15));
         issue(ra, rb, rop, model(ra, rb, rop), acc);
      end
      setReady(100);
      drain();

      check("final_scoreboard_empty", sb.size(), 0);
      $display("%0d/%0d checks passed", passCnt, checkCnt);
      $finish;
   end
endmodule

// File: doc/alu_pipe.md
ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 Parameter WIDTH, default 8: operand and result width; legal values are powers of two, 4 to 64.
REQ-002 clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 in_valid  input  1  the upstream operation is valid this cycle.
REQ-005 in_ready  output  1  the block accepts an operation this cycle.
REQ-006 opA  input  WIDTH  operand A.
REQ-007 opB  input  WIDTH  operand B.
REQ-008 opS  input  4  opcode.
REQ-009 out_valid  output  1  Result and flags are valid.
REQ-010 out_ready  input  1  downstream accepts the result.
REQ-011 Result  output  WIDTH  operation result.
REQ-012 flags  output  5  {E, V, N, Z, C}.

Function
REQ-013 An operation SHALL be accepted only on a cycle with in_valid=1 and in_ready=1; a result SHALL be consumed only on a cycle with out_valid=1 and out_ready=1.
REQ-014 The block SHALL be a two-stage pipeline: stage 1 registers opA, opB and opS; stage 2 registers Result and flags.
REQ-015 Without stalls, latency SHALL be 2 cycles from the accept edge to out_valid=1, with throughput of one operation per cycle.
REQ-016 Stage 2 SHALL advance when it is empty or its result is being consumed; stage 1 SHALL advance when it is empty or stage 2 advances; in_ready = !s1_valid || stage-2-advance (a combinational path from out_ready is permitted).
REQ-017 While out_valid=1 and out_ready=0, Result and flags SHALL hold stable and no operation SHALL be lost or duplicated.
REQ-018 Opcodes: 0 NOP (Result=0); 1 ADD A+B; 2 SUB A-B; 3 AND; 4 OR; 5 XOR; 6 INV ~A; 7 SHL A<<1; 8 SHR A>>1 logical; 9 ROL A by B[log2(WIDTH)-1:0]; 10 ROR likewise; 11 ASR A>>>1.
REQ-019 Opcodes 12-15 SHALL produce Result=0 with E=1; E SHALL be 0 for all other opcodes.
REQ-020 C SHALL be: ADD carry-out; SUB borrow (1 when A<B unsigned); SHL old A[WIDTH-1]; SHR/ASR old A[0]; 0 for all other opcodes.
REQ-021 V SHALL be signed two's-complement overflow for ADD/SUB, and 0 otherwise.
REQ-022 Z SHALL be (Result==0); N SHALL be Result[WIDTH-1]; this applies to every opcode, including NOP (Z=1).
REQ-023 Simultaneous accept and consume in the same cycle SHALL both take effect.

Reset
REQ-024 While rst_n=0 at a rising edge, both stage-valid bits SHALL clear, out_valid=0, Result=0 and flags=0.
REQ-025 Reset mid-operation SHALL discard all in-flight operations; in_ready SHALL be 1 in the first cycle after reset is released.
REQ-026 In-flight data SHALL never reappear after reset.

Configuration
REQ-027 Macro ALU_PIPE_SAT_EN: when defined, ADD SHALL saturate to all-ones on carry and SUB SHALL clamp to 0 on borrow; C and V SHALL report as for the unsaturated operation, and Z/N SHALL follow the saturated Result.
REQ-028 Without ALU_PIPE_SAT_EN, ADD and SUB SHALL wrap modulo 2^WIDTH.

Verification
REQ-029 WIDTH=8, A=15, B=51, opcodes 0-8 issued back-to-back with out_ready=1 -> results 0, 66, 220 (C=1), 00000011, 00111111, 00111100, 11110000, 00011110, 00000111 (C=1), one per cycle, starting 2 cycles after the first accept.
REQ-030 A=200, B=100, ADD -> Result=44, C=1, V=0 without the macro; Result=255, C=1 with ALU_PIPE_SAT_EN.
REQ-031 A=8'h81, B=3, ROL -> 8'h0C; ROR -> 8'h30; A=8'h80, ASR -> 8'hC0, N=1.
REQ-032 Issue 4 operations while out_ready is held 0 -> exactly 2 are accepted and in_ready=0 thereafter; release out_ready -> all 4 results emerge in order, with none dropped.
REQ-033 Assert rst_n=0 for 1 cycle with 2 operations in flight -> out_valid=0 and no stale result afterwards; opS=13 -> Result=0, E=1, Z=1.
